pipelined_alu: RTL and testbench

- Parametrised, handshaked successor to the processor's combinational ALU.
- Accepts one operation per valid/ready transfer and returns a registered result plus full flags (Zero, Negative, Carry, Overflow, Illegal).
- Adds XOR/NOR/SLTU/shifts and an optional iterative multiplier.
- Sits between the decode/operand stage and writeback of the multi-cycle datapath.

---
 rtl/pipelined_alu.sv | 184 ++++++++++++++++++
 tb/tb_pipelined_alu.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_alu.sv
// Handshaked, registered ALU with full flags and an optional radix-2 shift-add multiplier.
// One op is accepted per valid/ready transfer; non-MUL results appear after one edge, MUL after W edges.
module pipelined_alu #(
  parameter int W          = 32,
  parameter bit ENABLE_MUL = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] IN0,
  input  logic [W-1:0] IN1,
  input  logic [3:0]   ALUControl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         Zero,
  output logic         Negative,
  output logic         Carry,
  output logic         Overflow,
  output logic         Illegal
);

  localparam int SHW = $clog2(W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;

  logic [1:0]     state_q, state_d;
  logic [W-1:0]   res_q, res_d;
  logic           zero_q, zero_d, neg_q, neg_d, carry_q, carry_d;
  logic           ovf_q, ovf_d, ill_q, ill_d;
  logic [W-1:0]   mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [SHW-1:0] cnt_q, cnt_d;

  logic           accept, is_mul;
  logic [W:0]     sum_w, diff_w;
  logic [SHW-1:0] shamt;
  logic [W-1:0]   alu_res, mul_sum;
  logic           alu_c, alu_v, alu_ill;

  assign in_ready = rst_n & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
  assign accept   = in_valid & in_ready;
  assign is_mul   = ENABLE_MUL && (ALUControl == OP_MUL);

  assign sum_w   = {1'b0, IN0} + {1'b0, IN1};
  assign diff_w  = {1'b0, IN0} - {1'b0, IN1};
  assign shamt   = IN1[SHW-1:0];
  assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        alu_res = sum_w[W-1:0];
        alu_c   = sum_w[W];
        alu_v   = (IN0[W-1] == IN1[W-1]) && (sum_w[W-1] != IN0[W-1]);
      end
      OP_SUB: begin
        alu_res = diff_w[W-1:0];
        alu_c   = ~diff_w[W];
        alu_v   = (IN0[W-1] != IN1[W-1]) && (diff_w[W-1] != IN0[W-1]);
      end
      OP_OR:   alu_res = IN0 | IN1;
      OP_AND:  alu_res = IN0 & IN1;
      OP_XOR:  alu_res = IN0 ^ IN1;
      OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(IN0) < $signed(IN1))};
      OP_SLTU: alu_res = {{(W-1){1'b0}}, (IN0 < IN1)};
      OP_SLL:  alu_res = IN0 << shamt;
      OP_SRL:  alu_res = IN0 >> shamt;
      OP_SRA:  alu_res = $signed(IN0) >>> shamt;
      OP_NOR:  alu_res = ~(IN0 | IN1);
      OP_MUL:  alu_ill = ~ENABLE_MUL;
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    if (accept) begin
      if (is_mul) begin
        state_d  = S_BUSY;
        mcand_d  = IN0;
        mplier_d = IN1;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        state_d = S_DONE;
        res_d   = alu_res;
        zero_d  = (alu_res == '0);
        neg_d   = alu_res[W-1];
        carry_d = alu_c;
        ovf_d   = alu_v;
        ill_d   = alu_ill;
      end
    end else if ((state_q == S_DONE) && out_ready) begin
      state_d = S_IDLE;
    end

    // One multiplier bit per edge; the last step writes the final sum straight into the result.
    if (state_q == S_BUSY) begin
      acc_d    = mul_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == SHW'(W - 1)) begin
        state_d = S_DONE;
        res_d   = mul_sum;
        zero_d  = (mul_sum == '0);
        neg_d   = mul_sum[W-1];
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        ill_d   = 1'b0;
      end
    end
  end

  // NOTE: the multiplier datapath is reset along with the control state so an aborted MUL leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      res_q    <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign out       = res_q;
  assign Zero      = zero_q;
  assign Negative  = neg_q;
  assign Carry     = carry_q;
  assign Overflow  = ovf_q;
  assign Illegal   = ill_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// Bench for pipelined_alu: an arithmetic reference model with a pending-result queue checked every
// cycle, plus directed vectors with hand-computed literal results.
module tb_pipelined_alu;
  localparam int W = 32;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_OR  = 4'd2,  OP_AND  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_SLT = 4'd5,  OP_SLTU = 4'd6, OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8,  OP_SRA = 4'd9,  OP_MUL = 4'd10, OP_NOR  = 4'd11;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 64'sd1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in0, in1, out;
  logic [3:0]    ctl;
  logic          Zero, Negative, Carry, Overflow, Illegal;
  logic [4:0]    flags;

  logic          u_in_valid, u_in_ready, u_out_valid;
  logic [W-1:0]  u_in0, u_in1, u_out;
  logic [3:0]    u_ctl;
  logic          u_zero, u_neg, u_carry, u_ovf, u_ill;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  assign flags = {Zero, Negative, Carry, Overflow, Illegal};

  pipelined_alu #(.W(W), .ENABLE_MUL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .IN0(in0), .IN1(in1), .ALUControl(ctl), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow),
    .Illegal(Illegal)
  );

  pipelined_alu #(.W(W), .ENABLE_MUL(1'b0)) dut_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(u_in_valid), .in_ready(u_in_ready),
    .IN0(u_in0), .IN1(u_in1), .ALUControl(u_ctl), .out_valid(u_out_valid), .out_ready(1'b1),
    .out(u_out), .Zero(u_zero), .Negative(u_neg), .Carry(u_carry), .Overflow(u_ovf),
    .Illegal(u_ill)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z, n, c, v, ill;
  } exp_t;

  typedef struct {
    exp_t e;
    int   rdy;
  } pend_t;

  pend_t pend[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result and flags derived from plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    longint       sa, sb, s;
    logic [63:0]  prod;
    logic [W:0]   wide;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e = '0;
    case (op)
      OP_ADD: begin
        e.res = a + b;
        wide  = {1'b0, a} + {1'b0, b};
        e.c   = wide[W];
        s     = sa + sb;
        e.v   = (s > SMAX) || (s < SMIN);
      end
      OP_SUB: begin
        e.res = a - b;
        e.c   = (a >= b);
        s     = sa - sb;
        e.v   = (s > SMAX) || (s < SMIN);
      end
      OP_OR:   e.res = a | b;
      OP_AND:  e.res = a & b;
      OP_XOR:  e.res = a ^ b;
      OP_SLT:  e.res = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: e.res = (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  e.res = a << b[4:0];
      OP_SRL:  e.res = a >> b[4:0];
      OP_SRA:  e.res = 32'(sa >>> b[4:0]);
      OP_MUL: begin
        prod  = {32'b0, a} * {32'b0, b};
        e.res = prod[31:0];
      end
      OP_NOR:  e.res = ~(a | b);
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == '0);
    e.n = e.res[W-1];
    return e;
  endfunction

  // Scoreboard update: what the DUT must accept and release at this edge.
  always @(posedge clk) begin
    bit ev, ir;
    ev = rst_n && (pend.size() > 0) && (cyc >= pend[0].rdy);
    ir = rst_n && ((pend.size() == 0) || (ev && out_ready));
    cyc++;
    if (!rst_n) begin
      pend.delete();
    end else begin
      if (ev && out_ready) void'(pend.pop_front());
      if (in_valid && ir) pend.push_back('{model(ctl, in0, in1), cyc + ((ctl == OP_MUL) ? W : 0)});
    end
  end

  always @(negedge clk) begin
    bit ev, ir;
    if (!rst_n) begin
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd0);
      chk("reset out", out, 32'd0);
      chk("reset flags", 32'(flags), 32'd0);
    end else begin
      ev = (pend.size() > 0) && (cyc >= pend[0].rdy);
      ir = (pend.size() == 0) || (ev && out_ready);
      chk("model out_valid", 32'(out_valid), 32'(ev));
      chk("model in_ready", 32'(in_ready), 32'(ir));
      if (ev) begin
        chk("model out", out, pend[0].e.res);
        chk("model flags ZNCVI", 32'(flags),
            32'({pend[0].e.z, pend[0].e.n, pend[0].e.c, pend[0].e.v, pend[0].e.ill}));
      end
    end
  end

  // Presents one op and returns #1 after the edge that accepted it.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    ctl      = op;
    in0      = a;
    in1      = b;
    #1;
    for (int i = 0; i < 200; i++) begin
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) chk("send accept timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid is seen; stops on that negedge.
  task automatic wait_res(input string name, input int exp_lat);
    int n;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
    end
    chk(name, 32'(n), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; in0 = '0; in1 = '0; ctl = '0;
    u_in_valid = 1'b0; u_in0 = '0; u_in1 = '0; u_ctl = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    send(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    wait_res("ADD latency", 0);
    chk("ADD out", out, 32'h8000_0000);
    chk("ADD flags ZNCVI", 32'(flags), 32'b01010);

    send(OP_SUB, 32'd5, 32'd5);
    in_valid = 1'b1; ctl = OP_SUB; in0 = 32'd3; in1 = 32'd7;
    @(negedge clk);
    chk("SUB 5-5 out", out, 32'd0);
    chk("SUB 5-5 flags", 32'(flags), 32'b10100);
    chk("SUB b2b in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("SUB 3-7 out", out, 32'hFFFF_FFFC);
    chk("SUB 3-7 flags", 32'(flags), 32'b01000);
    chk("SUB 3-7 out_valid", 32'(out_valid), 32'd1);
    chk("SUB 3-7 in_ready", 32'(in_ready), 32'd1);

    send(OP_SRA, 32'h8000_0000, 32'h24);
    wait_res("SRA latency", 0);
    chk("SRA out", out, 32'hF800_0000);
    send(OP_SLT, 32'hFFFF_FFFF, 32'd1);
    wait_res("SLT latency", 0);
    chk("SLT out", out, 32'd1);
    send(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
    wait_res("SLTU latency", 0);
    chk("SLTU out", out, 32'd0);
    chk("SLTU Zero", 32'(Zero), 32'd1);

    // Back-to-back sweep; checked by the model every cycle.
    send(OP_XOR, 32'hA5A5_0F0F, 32'hFFFF_0000);
    send(OP_NOR, 32'h0000_00FF, 32'h0F00_0000);
    send(OP_SLL, 32'h1, 32'hFFFF_FFFF);
    send(OP_SRL, 32'h8000_0000, 32'd31);
    send(OP_ADD, 32'hFFFF_FFFF, 32'd1);
    send(OP_ADD, 32'h8000_0000, 32'h8000_0000);
    send(OP_SUB, 32'h8000_0000, 32'd1);
    send(OP_SUB, 32'd0, 32'd1);
    send(OP_OR, 32'h0, 32'h0);
    send(4'b1111, 32'h1234_5678, 32'h1);
    send(OP_SRA, 32'h7000_0000, 32'd3);
    send(OP_SLT, 32'd1, 32'h8000_0000);
    @(negedge clk);

    send(OP_MUL, 32'h0001_0001, 32'h0000_FFFF);
    in_valid = 1'b1; ctl = OP_ADD; in0 = 32'd1; in1 = 32'd1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) break;
      chk("MUL busy in_ready", 32'(in_ready), 32'd0);
      n++;
    end
    chk("MUL latency", 32'(n), 32'd32);
    chk("MUL out", out, 32'hFFFF_FFFF);
    chk("MUL flags", 32'(flags), 32'b01000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("ADD after MUL out", out, 32'd2);
    @(posedge clk); #1;

    out_ready = 1'b0;
    send(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    wait_res("AND latency", 0);
    for (int i = 0; i < 5; i++) begin
      chk("stall out", out, 32'hF000_F000);
      chk("stall flags", 32'(flags), 32'b01000);
      chk("stall in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b1; ctl = OP_OR; in0 = 32'd1; in1 = 32'd2;
    out_ready = 1'b1;
    #1 chk("stall release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("no-bubble out", out, 32'd3);
    chk("no-bubble out_valid", 32'(out_valid), 32'd1);

    send(OP_MUL, 32'd3, 32'd5);
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort out", out, 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(4'b1110, 32'hDEAD_BEEF, 32'h1);
    wait_res("illegal latency", 0);
    chk("illegal out", out, 32'd0);
    chk("illegal flags", 32'(flags), 32'b10001);

    u_in_valid = 1'b1; u_ctl = OP_MUL; u_in0 = 32'd3; u_in1 = 32'd5;
    #1 chk("nomul in_ready", 32'(u_in_ready), 32'd1);
    @(posedge clk); #1;
    u_in_valid = 1'b0;
    @(negedge clk);
    chk("nomul out_valid", 32'(u_out_valid), 32'd1);
    chk("nomul out", u_out, 32'd0);
    chk("nomul flags", 32'({u_zero, u_neg, u_carry, u_ovf, u_ill}), 32'b10001);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
